// File: rtl/cycles_period_meter.sv
// cycles_period_meter
// Measures the clock-cycle interval between consecutive rising edges of a
// same-clock event input. Reports the last interval, the running min/max and
// a sticky overflow that is set when an interval saturates the counter.
module cycles_period_meter #(
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             event_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic [WIDTH-1:0] period_min,
    output logic [WIDTH-1:0] period_max,
    output logic             overflow,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             event_q, event_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic [WIDTH-1:0] period_min_q, period_min_d;
    logic [WIDTH-1:0] period_max_q, period_max_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             evt_edge;

    // Saturating increment: the counter parks at all-ones once it gets there.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == ALL_ONES) ? v : v + ONE;
    endfunction

    // Rising edge of the event; a level already high at enable is not an edge
    // because the delayed copy tracks event_in in every state.
    assign evt_edge = event_in & ~event_q;

    // Next-state logic: clear has priority, then enable, then the FSM proper.
    always_comb begin
        state_d        = state_q;
        event_d        = event_in;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        period_min_d   = period_min_q;
        period_max_d   = period_max_q;
        overflow_d     = overflow_q;

        if (clear) begin
            // A simultaneous edge is dropped: it neither reports nor arms.
            period_d     = '0;
            period_min_d = ALL_ONES;
            period_max_d = '0;
            overflow_d   = 1'b0;
            cnt_d        = '0;
            state_d      = enable ? ARMED : IDLE;
        end else if (!enable) begin
            // Results are retained so software can still read them.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Edges seen while idle never arm; the next one will.
                    state_d = ARMED;
                    cnt_d   = '0;
                end
                ARMED: begin
                    if (evt_edge) begin
                        state_d = MEASURE;
                        cnt_d   = ONE;
                    end
                end
                MEASURE: begin
                    if (evt_edge) begin
                        // cnt already holds t1 - t0 when the closing edge is sampled.
                        period_d       = cnt_q;
                        period_valid_d = 1'b1;
                        period_min_d   = (cnt_q < period_min_q) ? cnt_q : period_min_q;
                        period_max_d   = (cnt_q > period_max_q) ? cnt_q : period_max_q;
                        cnt_d          = ONE;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                        if (cnt_d == ALL_ONES) begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and result registers; reset aborts any interval in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            event_q        <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            period_min_q   <= ALL_ONES;
            period_max_q   <= '0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            event_q        <= event_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            period_min_q   <= period_min_d;
            period_max_q   <= period_max_d;
            overflow_q     <= overflow_d;
            busy_q         <= busy_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign period_min   = period_min_q;
    assign period_max   = period_max_q;
    assign overflow     = overflow_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_cycles_period_meter.sv
// Testbench for cycles_period_meter: table of pulse-interval vectors plus
// hand-written sequences for clear/edge collision, held level, saturation
// (8-bit instance) and asynchronous reset mid-interval.
module tb_cycles_period_meter;

    localparam logic [63:0] ONES33 = 64'h1_FFFF_FFFF;
    localparam logic [63:0] ONES8  = 64'hFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        event_in = 1'b0;

    logic [32:0] period, period_min, period_max;
    logic        period_valid, overflow, busy;
    logic [7:0]  period8, period_min8, period_max8;
    logic        period_valid8, overflow8, busy8;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    cycles_period_meter u_dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .event_in(event_in), .period(period), .period_valid(period_valid),
        .period_min(period_min), .period_max(period_max),
        .overflow(overflow), .busy(busy)
    );

    cycles_period_meter #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .event_in(event_in), .period(period8), .period_valid(period_valid8),
        .period_min(period_min8), .period_max(period_max8),
        .overflow(overflow8), .busy(busy8)
    );

    typedef struct packed {
        logic [1:0]      ngaps;
        logic [2:0][7:0] gaps;
        logic [7:0]      exp_min;
        logic [7:0]      exp_max;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
    endtask

    task automatic idle(input int n, output int nvalid);
        nvalid = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (period_valid) nvalid++;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        int stray;
        vecs[0] = '{ngaps: 2'd3, gaps: {8'd10, 8'd10, 8'd10}, exp_min: 8'd10, exp_max: 8'd10};
        vecs[1] = '{ngaps: 2'd3, gaps: {8'd7,  8'd12, 8'd5 }, exp_min: 8'd5,  exp_max: 8'd12};
        vecs[2] = '{ngaps: 2'd3, gaps: {8'd3,  8'd2,  8'd2 }, exp_min: 8'd2,  exp_max: 8'd3};
        vecs[3] = '{ngaps: 2'd2, gaps: {8'd0,  8'd3,  8'd20}, exp_min: 8'd3,  exp_max: 8'd20};

        // Reset values
        tick();
        tick();
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_min", period_min, ONES33);
        check("rst_min8", period_min8, ONES8);
        check("rst_max", period_max, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);

        reset = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        enable = 1'b1;
        tick();
        check("armed_busy", busy, 1);

        // Table-driven interval vectors
        foreach (vecs[i]) begin
            do_clear();
            check($sformatf("v%0d_clr_min", i), period_min, ONES33);
            check($sformatf("v%0d_clr_max", i), period_max, 0);
            idle(2, nv);
            pulse();
            check($sformatf("v%0d_arm_valid", i), period_valid, 0);
            stray = 0;
            for (int j = 0; j < int'(vecs[i].ngaps); j++) begin
                idle(int'(vecs[i].gaps[j]) - 1, nv);
                stray += nv;
                pulse();
                check($sformatf("v%0d_e%0d_valid", i, j), period_valid, 1);
                check($sformatf("v%0d_e%0d_period", i, j), period, 64'(vecs[i].gaps[j]));
            end
            idle(1, nv);
            stray += nv;
            check($sformatf("v%0d_stray_valid", i), stray, 0);
            check($sformatf("v%0d_min", i), period_min, 64'(vecs[i].exp_min));
            check($sformatf("v%0d_max", i), period_max, 64'(vecs[i].exp_max));
            check($sformatf("v%0d_overflow", i), overflow, 0);
        end

        // Dropping enable keeps results; level held high at enable is ignored
        enable = 1'b0;
        idle(3, nv);
        check("dis_busy", busy, 0);
        check("dis_period", period, 3);
        check("dis_min", period_min, 3);
        check("dis_max", period_max, 20);
        event_in = 1'b1;
        idle(2, nv);
        enable = 1'b1;
        idle(4, nv);
        check("held_no_valid", nv, 0);
        check("held_busy", busy, 1);
        event_in = 1'b0;
        idle(3, nv);
        pulse();
        check("held_arm_valid", period_valid, 0);
        idle(5, nv);
        stray = nv;
        pulse();
        check("held_valid", period_valid, 1);
        check("held_period", period, 6);
        idle(2, nv);
        check("held_single_valid", stray + nv, 0);

        // clear coincident with an edge during MEASURE
        idle(3, nv);
        event_in = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        event_in = 1'b0;
        check("clredge_valid", period_valid, 0);
        check("clredge_min", period_min, ONES33);
        check("clredge_max", period_max, 0);
        check("clredge_period", period, 0);
        idle(3, nv);
        pulse();
        check("clredge_arm_valid", period_valid, 0);
        idle(6, nv);
        pulse();
        check("clredge_valid2", period_valid, 1);
        check("clredge_period2", period, 7);
        check("clredge_min2", period_min, 7);

        // Saturation on the 8-bit instance: edges 300 cycles apart
        do_clear();
        idle(2, nv);
        pulse();
        idle(100, nv);
        check("sat_ovf_early", overflow8, 0);
        idle(199, nv);
        check("sat_ovf_set", overflow8, 1);
        check("sat_ovf33", overflow, 0);
        pulse();
        check("sat_valid8", period_valid8, 1);
        check("sat_period8", period8, ONES8);
        check("sat_period33", period, 300);
        check("sat_min8", period_min8, ONES8);
        check("sat_max8", period_max8, ONES8);
        idle(4, nv);
        pulse();
        check("sat_next_period8", period8, 5);
        check("sat_sticky", overflow8, 1);
        check("sat_next_min8", period_min8, 5);
        check("sat_next_max8", period_max8, ONES8);
        do_clear();
        check("sat_clr_ovf", overflow8, 0);

        // Asynchronous reset mid-interval
        idle(2, nv);
        pulse();
        idle(3, nv);
        reset = 1'b0;
        #1;
        check("arst_period", period, 0);
        check("arst_valid", period_valid, 0);
        check("arst_min", period_min, ONES33);
        check("arst_max", period_max, 0);
        check("arst_busy", busy, 0);
        check("arst_ovf", overflow, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("arst_rearm_busy", busy, 1);
        idle(2, nv);
        stray = nv;
        pulse();
        check("arst_arm_valid", period_valid, 0);
        idle(3, nv);
        stray += nv;
        pulse();
        check("arst_valid2", period_valid, 1);
        check("arst_period2", period, 4);
        idle(2, nv);
        check("arst_single_valid", stray + nv, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
